// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator: Ctrl encoding,
// instruction field positions, legal datapath widths and the S1 request payload.
package imm_pkg;

  localparam int unsigned IMM_W         = 26;
  localparam int unsigned CTRL_W        = 4;
  localparam int unsigned HW_LSB        = 21;
  localparam int unsigned HW_W          = 2;
  localparam int unsigned MOV_LSB       = 5;
  localparam int unsigned MOV_W         = 16;
  localparam int unsigned DATA_W_NARROW = 32;
  localparam int unsigned DATA_W_WIDE   = 64;

  localparam logic [CTRL_W-1:0] IMM_ITYPE = 4'd0;
  localparam logic [CTRL_W-1:0] IMM_DTYPE = 4'd1;
  localparam logic [CTRL_W-1:0] IMM_B     = 4'd2;
  localparam logic [CTRL_W-1:0] IMM_CBZ   = 4'd3;
  localparam logic [CTRL_W-1:0] IMM_MOVZ  = 4'd4;
  localparam logic [CTRL_W-1:0] IMM_MOVN  = 4'd5;
  localparam logic [CTRL_W-1:0] IMM_MOVK  = 4'd6;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [IMM_W-1:0]  imm26;
  } imm_req_t;

  function automatic logic is_wide_move(input logic [CTRL_W-1:0] ctrl);
    return (ctrl == IMM_MOVZ) || (ctrl == IMM_MOVN) || (ctrl == IMM_MOVK);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: (ctrl, imm26, base) -> (result, err).
// Everything is formed at 64 bits and then truncated to DATA_W.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [IMM_W-1:0]  imm26,
  input  logic [DATA_W-1:0] base,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  logic [HW_W-1:0] hw;
  logic [5:0]      sh;
  logic [63:0]     mov_field;
  logic [63:0]     mov_mask;
  logic [63:0]     base_w;
  logic [63:0]     wide_q;

  always_comb begin
    hw        = imm26[HW_LSB +: HW_W];
    sh        = {hw, 4'b0000};
    mov_field = 64'(imm26[MOV_LSB +: MOV_W]) << sh;
    mov_mask  = 64'h0000_0000_0000_FFFF << sh;
    base_w    = 64'(base);
    wide_q    = '0;
    err       = 1'b0;

    case (ctrl)
      IMM_ITYPE: wide_q = imm26[22] ? 64'({imm26[21:10], 12'h000}) : 64'(imm26[21:10]);
      IMM_DTYPE: wide_q = {{55{imm26[20]}}, imm26[20:12]};
      IMM_B:     wide_q = {{36{imm26[25]}}, imm26, 2'b00};
      IMM_CBZ:   wide_q = {{43{imm26[23]}}, imm26[23:5], 2'b00};
      IMM_MOVZ:  wide_q = mov_field;
      IMM_MOVN:  wide_q = ~mov_field;
      IMM_MOVK:  wide_q = (base_w & ~mov_mask) | mov_field;
      default:   err    = 1'b1;
    endcase

    // A 32-bit datapath has only two 16-bit halfwords to target.
    if (is_wide_move(ctrl) && (DATA_W == DATA_W_NARROW) && hw[1]) begin
      err = 1'b1;
    end

    result = err ? '0 : DATA_W'(wide_q);
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate generator (S1 request register, S2 result register).
// Define IMMGEN_MOVK_CHAIN_EN to add the MOVZ/MOVN/MOVK -> MOVK chaining register.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  Imm26,
  input  logic [CTRL_W-1:0] Ctrl,
  input  logic [DATA_W-1:0] MergeBase,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] BusImm,
  output logic              Err
);

  logic              s1_valid;
  imm_req_t          s1_req;
  logic [DATA_W-1:0] s1_base;
  logic              s1_take;
  logic              s2_take;
  logic              s1_to_s2;
  logic              accept;
  logic [DATA_W-1:0] dec_base;
  logic [DATA_W-1:0] dec_result;
  logic              dec_err;

  // A stage moves when it is empty or its consumer takes its contents this cycle.
  assign s2_take  = !out_valid || out_ready;
  assign s1_take  = !s1_valid || s2_take;
  assign s1_to_s2 = s1_valid && s2_take;
  assign in_ready = s1_take;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
      s1_base  <= '0;
    end else begin
      if (s1_take) begin
        s1_valid <= accept;
      end
      if (accept) begin
        s1_req.ctrl  <= Ctrl;
        s1_req.imm26 <= Imm26;
        s1_base      <= MergeBase;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      out_valid <= 1'b0;
      BusImm    <= '0;
      Err       <= 1'b0;
    end else begin
      if (s2_take) begin
        out_valid <= s1_valid;
      end
      if (s1_to_s2) begin
        BusImm <= dec_result;
        Err    <= dec_err;
      end
    end
  end

`ifdef IMMGEN_MOVK_CHAIN_EN
  logic [DATA_W-1:0] chain_q;
  logic              chain_valid;
  logic              chain_load;

  // MOVK picks up the previous legal wide-move result instead of its sampled base.
  assign dec_base   = ((s1_req.ctrl == IMM_MOVK) && chain_valid) ? chain_q : s1_base;
  assign chain_load = is_wide_move(s1_req.ctrl) && !dec_err;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      chain_valid <= 1'b0;
      chain_q     <= '0;
    end else if (s1_to_s2) begin
      chain_valid <= chain_load;
      if (chain_load) begin
        chain_q <= dec_result;
      end
    end
  end
`else
  assign dec_base = s1_base;
`endif

  imm_decode #(
    .DATA_W(DATA_W)
  ) u_decode (
    .ctrl  (s1_req.ctrl),
    .imm26 (s1_req.imm26),
    .base  (dec_base),
    .result(dec_result),
    .err   (dec_err)
  );

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: 64-bit and 32-bit instances share stimulus
// and are scored against a request-order reference model plus constant vector tables.
module tb_imm_extend_pipe;
  import imm_pkg::*;

  typedef struct {
    logic [3:0]  c;
    logic [25:0] im;
    logic [63:0] b;
    logic [63:0] e64;
    logic        r64;
    logic [31:0] e32;
    logic        r32;
  } vec_t;

  typedef struct {
    logic [63:0] v;
    logic        e;
    int          acc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [25:0] Imm26 = '0;
  logic [3:0]  Ctrl = '0;
  logic [63:0] MergeBase = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, Err;
  logic [63:0] BusImm;
  logic        in_ready32, out_valid32, Err32;
  logic [31:0] BusImm32;

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  bit   lat_chk = 1'b0;
  bit   chv [2];
  logic [63:0] chreg [2];
  bit   hold [2];
  logic [63:0] hbus [2];
  logic he [2];
  exp_t q64[$];
  exp_t q32[$];
  vec_t tab [12];
  vec_t nv;

  always #5 CLK = ~CLK;

  imm_extend_pipe #(.DATA_W(64)) dut (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .Imm26(Imm26), .Ctrl(Ctrl), .MergeBase(MergeBase), .out_valid(out_valid),
    .out_ready(out_ready), .BusImm(BusImm), .Err(Err));

  imm_extend_pipe #(.DATA_W(32)) dut32 (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready32),
    .Imm26(Imm26), .Ctrl(Ctrl), .MergeBase(MergeBase[31:0]), .out_valid(out_valid32),
    .out_ready(out_ready), .BusImm(BusImm32), .Err(Err32));

  function automatic logic [25:0] mk_i(input logic [11:0] imm12, input logic sh);
    return {3'b000, sh, imm12, 10'd0};
  endfunction
  function automatic logic [25:0] mk_d(input logic [8:0] imm9);
    return {5'd0, imm9, 12'd0};
  endfunction
  function automatic logic [25:0] mk_m(input logic [15:0] imm16, input logic [1:0] hw);
    return {3'b000, hw, imm16, 5'd0};
  endfunction

  // Reference model: arithmetic on the field values, applied in request order.
  function automatic exp_t model_step(input int k, input logic [3:0] c,
                                      input logic [25:0] im, input logic [63:0] b);
    longint      s;
    logic [63:0] v, base, z, fld;
    int          sh;
    bit          e;
    exp_t        r;
    e = 1'b0; v = '0; s = 0;
    base = (k == 1) ? b : {32'd0, b[31:0]};
`ifdef IMMGEN_MOVK_CHAIN_EN
    if (c == 4'd6 && chv[k]) base = chreg[k];
`endif
    sh = 16 * int'(im[22:21]);
    case (c)
      4'd0: begin s = longint'(im[21:10]); if (im[22]) s = s * 4096; v = 64'(s); end
      4'd1: begin s = longint'(im[20:12]); if (s >= 256) s = s - 512; v = 64'(s); end
      4'd2: begin s = longint'(im) * 4; if (s >= 134217728) s = s - 268435456; v = 64'(s); end
      4'd3: begin s = longint'(im[23:5]) * 4; if (s >= 1048576) s = s - 2097152; v = 64'(s); end
      4'd4, 4'd5, 4'd6: begin
        if (k == 0 && sh >= 32) e = 1'b1;
        else begin
          z = 64'(im[20:5]) << sh;
          fld = (base >> sh) & 64'hFFFF;
          if (c == 4'd4) v = z;
          else if (c == 4'd5) v = ~z;
          else v = base - (fld << sh) + z;
        end
      end
      default: e = 1'b1;
    endcase
    if (e) v = '0;
    if (k == 0) v[63:32] = '0;
    if (c >= 4'd4 && c <= 4'd6 && !e) begin chv[k] = 1'b1; chreg[k] = v; end
    else chv[k] = 1'b0;
    r.v = v; r.e = e; r.acc = cycle;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic mon(input int k, input logic ov, input logic inr, input logic e,
                     input logic [63:0] bus, input logic use_tab,
                     input logic [63:0] tv, input logic te);
    exp_t x;
    bit   empty;
    if (hold[k]) begin
      chk(k == 1 ? "hold_valid64" : "hold_valid32", 64'(ov), 64'd1);
      chk(k == 1 ? "hold_bus64" : "hold_bus32", bus, hbus[k]);
      chk(k == 1 ? "hold_err64" : "hold_err32", 64'(e), 64'(he[k]));
    end
    if (ov && out_ready) begin
      empty = (k == 1) ? (q64.size() == 0) : (q32.size() == 0);
      if (empty) begin
        checks++; errors++;
        $display("FAIL unexpected_out w%0d: got %h with nothing outstanding", k, bus);
      end else begin
        if (k == 1) x = q64.pop_front(); else x = q32.pop_front();
        chk(k == 1 ? "bus64" : "bus32", bus, x.v);
        chk(k == 1 ? "err64" : "err32", 64'(e), 64'(x.e));
        if (lat_chk) chk(k == 1 ? "latency64" : "latency32", 64'(cycle - x.acc), 64'd2);
      end
    end
    hold[k] = ov && !out_ready;
    hbus[k] = bus;
    he[k]   = e;
    if (in_valid && inr) begin
      x = model_step(k, Ctrl, Imm26, MergeBase);
      if (use_tab) begin x.v = tv; x.e = te; end
      if (k == 1) q64.push_back(x); else q32.push_back(x);
    end
  endtask

  task automatic cyc_step(input logic rst, input logic iv, input logic ordy,
                          input vec_t v, input logic use_tab);
    @(negedge CLK);
    Reset = rst; in_valid = iv; out_ready = ordy;
    Ctrl = v.c; Imm26 = v.im; MergeBase = v.b;
    #1;
    cycle++;
    if (rst) begin
      q64.delete(); q32.delete();
      chv[0] = 1'b0; chv[1] = 1'b0; hold[0] = 1'b0; hold[1] = 1'b0;
    end else begin
      mon(1, out_valid, in_ready, Err, BusImm, use_tab, v.e64, v.r64);
      mon(0, out_valid32, in_ready32, Err32, 64'(BusImm32), use_tab, 64'(v.e32), v.r32);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q64.size() != 0 || q32.size() != 0) && n < 20) begin
      cyc_step(1'b0, 1'b0, 1'b1, nv, 1'b0);
      n++;
    end
    chk(name, 64'(q64.size() + q32.size()), 64'd0);
    repeat (2) cyc_step(1'b0, 1'b0, 1'b1, nv, 1'b0);
  endtask

  function automatic vec_t rand_vec(input bit legal_only);
    vec_t v;
    v = nv;
    if (!legal_only && $urandom_range(0, 9) == 0) v.c = 4'($urandom_range(7, 15));
    else v.c = 4'($urandom_range(0, 6));
    v.im = 26'($urandom);
    v.b  = {$urandom, $urandom};
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_bus"}, BusImm, 64'd0);
    chk({tag, "_err"}, 64'(Err), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid32"}, 64'(out_valid32), 64'd0);
    chk({tag, "_bus32"}, 64'(BusImm32), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n, i;
    bit   saw_low;
    logic [63:0] ch64;
    logic [31:0] ch32;

    nv = '{4'd0, 26'd0, 64'd0, 64'd0, 1'b0, 32'd0, 1'b0};
    tab[0]  = '{IMM_DTYPE, mk_d(9'h1F0), 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 32'hFFFF_FFF0, 1'b0};
    tab[1]  = '{IMM_ITYPE, mk_i(12'hABC, 1'b1), 64'd0, 64'h0000_0000_00AB_C000, 1'b0, 32'h00AB_C000, 1'b0};
    tab[2]  = '{IMM_MOVZ, mk_m(16'h1234, 2'd3), 64'd0, 64'h1234_0000_0000_0000, 1'b0, 32'h0, 1'b1};
    tab[3]  = '{IMM_MOVN, mk_m(16'h0000, 2'd0), 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
    tab[4]  = '{IMM_ITYPE, mk_i(12'hFFF, 1'b0), 64'd0, 64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0};
    tab[5]  = '{IMM_MOVK, mk_m(16'h0000, 2'd1), 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_0000_FFFF, 1'b0, 32'h0000_FFFF, 1'b0};
    tab[6]  = '{4'd9, 26'h3FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 32'd0, 1'b1};
    tab[7]  = '{IMM_MOVZ, mk_m(16'h1234, 2'd2), 64'd0, 64'h0000_1234_0000_0000, 1'b0, 32'h0, 1'b1};
    tab[8]  = '{IMM_B, 26'h3FF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0};
    tab[9]  = '{IMM_CBZ, {2'b00, 19'h40000, 5'd0}, 64'd0, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 32'hFFF0_0000, 1'b0};
    tab[10] = '{IMM_B, 26'h000_0001, 64'd0, 64'h0000_0000_0000_0004, 1'b0, 32'h0000_0004, 1'b0};
    tab[11] = '{IMM_MOVK, mk_m(16'h5555, 2'd0), 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_5555, 1'b0, 32'h89AB_5555, 1'b0};

    // Power-on reset.
    repeat (2) cyc_step(1'b1, 1'b1, 1'b0, tab[0], 1'b0);
    cyc_step(1'b0, 1'b0, 1'b0, nv, 1'b0);
    check_reset_state("por");

    // Constant vector table, back-to-back with no stall.
    lat_chk = 1'b1;
    for (int k = 0; k < 12; k++) cyc_step(1'b0, 1'b1, 1'b1, tab[k], 1'b1);
    drain("drain_table");

    // MOVZ followed immediately by MOVK with a zero MergeBase.
`ifdef IMMGEN_MOVK_CHAIN_EN
    ch64 = 64'h0000_0000_DEAD_BEEF; ch32 = 32'hDEAD_BEEF;
`else
    ch64 = 64'h0000_0000_DEAD_0000; ch32 = 32'hDEAD_0000;
`endif
    v = '{IMM_MOVZ, mk_m(16'hBEEF, 2'd0), 64'd0, 64'h0000_0000_0000_BEEF, 1'b0, 32'h0000_BEEF, 1'b0};
    cyc_step(1'b0, 1'b1, 1'b1, v, 1'b1);
    v = '{IMM_MOVK, mk_m(16'hDEAD, 2'd1), 64'd0, ch64, 1'b0, ch32, 1'b0};
    cyc_step(1'b0, 1'b1, 1'b1, v, 1'b1);
    drain("drain_chain");
    lat_chk = 1'b0;

    // Backpressure: five requests, consumer stalled for the first four cycles.
    n = 0; i = 0; saw_low = 1'b0;
    while (i < 5 && n < 40) begin
      cyc_step(1'b0, 1'b1, (n >= 4), rand_vec(1'b1), 1'b0);
      if (!in_ready) saw_low = 1'b1;
      else i++;
      n++;
    end
    chk("bp_accepted", 64'(i), 64'd5);
    chk("bp_in_ready_dropped", 64'(saw_low), 64'd1);
    drain("drain_bp");

    // Randomised traffic with random stalls and illegal codes.
    for (int k = 0; k < 400; k++)
      cyc_step(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rand_vec(1'b0), 1'b0);
    drain("drain_random");

    // Reset mid-stream: in-flight requests must never appear.
    repeat (2) cyc_step(1'b0, 1'b1, 1'b0, rand_vec(1'b1), 1'b0);
    repeat (2) cyc_step(1'b1, 1'b1, 1'b1, rand_vec(1'b1), 1'b0);
    cyc_step(1'b0, 1'b0, 1'b1, nv, 1'b0);
    check_reset_state("midrst");
    drain("drain_after_reset");
    lat_chk = 1'b1;
    cyc_step(1'b0, 1'b1, 1'b1, tab[1], 1'b1);
    drain("drain_post_reset_req");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate generator for the datapath's decode stage; successor to the single-cycle sign extender. Decodes the instruction immediate field per a 4-bit control code into a DATA_W-bit immediate, adds MOVN/MOVK and hw-field-driven wide-move shifts, and exposes valid/ready handshakes on both sides. It has a two-stage register pipeline and an optional MOVZ→MOVK chaining register.

## Interface
- DATA_W, 64: immediate/datapath width; legal values 32 or 64.
- CLK  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block accepts request this cycle.
- Imm26  input  26  instruction bits [25:0].
- Ctrl  input  4  immediate type (encoding below).
- MergeBase  input  DATA_W  register value for MOVK merge; sampled with the request.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- BusImm  output  DATA_W  generated immediate.
- Err  output  1  illegal Ctrl/hw for this result; qualified by out_valid.

## Operation
- Ctrl 0 ITYPE: zero-extend Imm26[21:10]; if Imm26[22]=1, shift left 12.
- Ctrl 1 DTYPE: sign-extend Imm26[20:12] (9 bits).
- Ctrl 2 B: sign-extend {Imm26[25:0],2'b0}.
- Ctrl 3 CBZ: sign-extend {Imm26[23:5],2'b0}.
- Ctrl 4 MOVZ: Imm26[20:5] << (16·hw); hw = Imm26[22:21].
- Ctrl 5 MOVN: bitwise NOT of the MOVZ value.
- Ctrl 6 MOVK: base with bits [16·hw+15:16·hw] replaced by Imm26[20:5]; all other base bits unchanged.
- Ctrl 7–15: BusImm = 0, Err = 1.
- DATA_W=32 with a wide move (4/5/6) and hw ≥ 2: BusImm = 0, Err = 1.
- All results are truncated/extended to exactly DATA_W bits. For DATA_W=32, the B/CBZ sign bit is still the top field bit.
- Stage 1 (S1) registers Imm26, Ctrl and MergeBase on acceptance (in_valid & in_ready).
- Stage 2 (S2) computes the result from S1 during the S1→S2 transfer and registers BusImm/Err.
- Each stage advances when it is empty or its downstream consumer takes its contents.
- in_ready = !(S1 full & S2 full & !out_ready).
- Results leave in strict request order. None are dropped or duplicated.
- Errored requests flow through the pipeline normally.

## Timing
- Latency: 2 cycles from acceptance to out_valid, with no stall. Throughput: 1 per cycle while out_ready=1.
- While out_valid & !out_ready, BusImm and Err hold stable and S2 holds.
- With the pipe full and stalled, in_ready=0. S1 refills in the same cycle S2 drains.
- Reset, including mid-operation: S1/S2 valid flags = 0, so out_valid = 0. BusImm = 0, Err = 0, chain_valid = 0, in_ready = 1 in the cycle after Reset.
- Requests in flight during Reset are discarded.
- in_valid is ignored while Reset is high.

## Configuration
- IMMGEN_MOVK_CHAIN_EN defined: the block has a chain register (DATA_W bits) plus chain_valid.
  - Every S1→S2 transfer of a legal MOVZ/MOVN/MOVK writes its result into the chain register and sets chain_valid.
  - Every other transfer, including errored ones, clears chain_valid.
  - A MOVK computed while chain_valid=1 uses the chain register as its base instead of its sampled MergeBase.
  - This allows back-to-back MOVZ/MOVK sequences without register-file writeback.
- Macro not defined: MOVK always uses its sampled MergeBase, and the chain logic is absent.

## Structure
- Shared package imm_pkg holds the Ctrl encoding constants (IMM_ITYPE … IMM_MOVK), the hw field position, and the legal DATA_W values.
- One sub-module, imm_decode: purely combinational (Ctrl, Imm26, base) → (result, err). It is instantiated between S1 and S2.

## Test plan
- Reset: hold Reset 2 cycles mid-stream → out_valid=0, BusImm=0, Err=0 next cycle, in_ready=1. The in-flight request never appears.
- Decode sweep, DATA_W=64, out_ready=1:
  - DTYPE Imm26[20:12]=9'h1F0 → 64'hFFFF_FFFF_FFFF_FFF0.
  - ITYPE imm12=12'hABC, sh=1 → 64'h0000_0000_00AB_C000.
  - Each appears exactly 2 cycles after acceptance.
- Wide moves:
  - MOVZ imm16=16'h1234, hw=3 → 64'h1234_0000_0000_0000.
  - MOVN imm16=0, hw=0 → all ones.
  - MOVK on MergeBase=64'hFFFF_FFFF_FFFF_FFFF, imm16=16'h0000, hw=1 → 64'hFFFF_FFFF_0000_FFFF.
- Backpressure: stream 5 requests, out_ready low for 4 cycles → in_ready drops after the pipe fills, BusImm stays stable, all 5 emerge in order.
- Errors:
  - Ctrl=4'd9 → Err=1, BusImm=0.
  - DATA_W=32 MOVZ hw=2 → Err=1.
  - The next legal request is unaffected.
- Chain (macro on): MOVZ 16'hBEEF hw=0, then immediately MOVK 16'hDEAD hw=1 with MergeBase=0 → second result 64'h0000_0000_DEAD_BEEF.
  - With the macro off, the same sequence gives 64'h0000_0000_DEAD_0000.
